// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder.
//   state_e   : controller states (IDLE, RUN, DONE)
//   cnt_width : bit width needed for a digit counter covering 0..n-1
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A counter must still be at least one bit wide when only one digit exists.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder used for one digit of the serial add.
// Ports:
//   a_d, b_d : DIGIT-bit operand digits
//   cin      : carry into bit 0
//   s_d      : DIGIT-bit partial sum
//   cout     : carry out of the top bit
//   c_msb    : carry into the top bit (overflow detection on the last digit)
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    s_d  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
      c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: a + b + c_in over WIDTH bits, DIGIT bits per clock,
// LSB first. The result registers only change on the final digit, so sum,
// c_out and overflow stay stable until the next completion.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, accepted in IDLE or DONE
//   a, b, c_in   : operands, captured on an accepted start
//   busy         : high while digits are being added (RUN)
//   done         : one-cycle pulse when the result registers have updated
//   sum          : result of the last completed addition
//   c_out        : unsigned carry-out of the last completed addition
//   overflow     : signed overflow of the last completed addition
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding one digit per cycle
// DONE  | result just loaded; may accept a new start back-to-back
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              c_out_q, c_out_d;
  logic              ovf_q, ovf_d;

  logic [DIGIT-1:0]       dig_sum;
  logic                   dig_cout;
  logic                   dig_cmsb;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;
  logic                   accept;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a_d   (a_q[DIGIT-1:0]),
    .b_d   (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .s_d   (dig_sum),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  // New digit enters at the MSB end; after N digits the LSB digit has
  // migrated down to bit 0. The concatenation also covers WIDTH == DIGIT.
  assign acc_cat  = {dig_sum, acc_q};
  assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_cout;
        acc_d   = acc_next;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = acc_next;
          c_out_d = dig_cout;
          ovf_d   = dig_cout ^ dig_cmsb;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      carry_d = c_in;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mst_e;
  typedef struct packed {
    logic       c;
    logic       v;
    logic [7:0] s;
  } res_t;

  localparam int MW[3] = '{8, 8, 4};
  localparam int MN[3] = '{8, 2, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [2:0] cin_v   = '0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [3:0] a2 = '0, b2 = '0;

  logic [2:0] busy_v, done_v, cout_v, ovf_v;
  logic [7:0] sum0, sum1;
  logic [3:0] sum2;

  int tests = 0;
  int fails = 0;

  mst_e mst[3]   = '{M_IDLE, M_IDLE, M_IDLE};
  int   mcnt[3]  = '{0, 0, 0};
  res_t held[3]  = '{'0, '0, '0};
  res_t q0[$], q1[$], q2[$];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a0), .b(b0), .c_in(cin_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .c_out(cout_v[0]), .overflow(ovf_v[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a1), .b(b1), .c_in(cin_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .c_out(cout_v[1]), .overflow(ovf_v[1])
  );

  serial_adder #(.WIDTH(4), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a2), .b(b2), .c_in(cin_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum2), .c_out(cout_v[2]), .overflow(ovf_v[2])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t ref_add(input int w, input logic [7:0] a, input logic [7:0] b,
                                   input logic c);
    int unsigned m;
    int unsigned t;
    res_t r;
    m   = (32'd1 << w) - 1;
    t   = (a & m) + (b & m) + {31'd0, c};
    r.s = 8'(t & m);
    r.c = ((t >> w) & 1) != 0;
    r.v = (a[w-1] == b[w-1]) && (r.s[w-1] != a[w-1]);
    return r;
  endfunction

  function automatic res_t op_of(input int i);
    case (i)
      0:       return ref_add(MW[0], a0, b0, cin_v[0]);
      1:       return ref_add(MW[1], a1, b1, cin_v[1]);
      default: return ref_add(MW[2], {4'd0, a2}, {4'd0, b2}, cin_v[2]);
    endcase
  endfunction

  function automatic logic [31:0] sum_of(input int i);
    case (i)
      0:       return {24'd0, sum0};
      1:       return {24'd0, sum1};
      default: return {28'd0, sum2};
    endcase
  endfunction

  task automatic sb_push(input int i, input res_t r);
    case (i)
      0:       q0.push_back(r);
      1:       q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endtask

  task automatic sb_flush(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic sb_pop(input int i, output res_t r, output bit ok);
    r  = '0;
    ok = 1'b1;
    case (i)
      0:       if (q0.size() > 0) r = q0.pop_front(); else ok = 1'b0;
      1:       if (q1.size() > 0) r = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) r = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Reference controller: tracks acceptance and RUN length independently.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mst[i]  = M_IDLE;
        mcnt[i] = 0;
        held[i] = '0;
        sb_flush(i);
      end else if (mst[i] == M_RUN) begin
        mcnt[i] = mcnt[i] + 1;
        if (mcnt[i] == MN[i]) mst[i] = M_DONE;
      end else if (start_v[i]) begin
        sb_push(i, op_of(i));
        mst[i]  = M_RUN;
        mcnt[i] = 0;
      end else begin
        mst[i] = M_IDLE;
      end
    end
  end

  // Scoreboard compare away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      res_t r;
      bit   ok;
      if (mst[i] == M_DONE) begin
        sb_pop(i, r, ok);
        chk($sformatf("d%0d_sb_entry", i), {31'd0, ok}, 32'd1);
        held[i] = r;
      end
      chk($sformatf("d%0d_busy", i), {31'd0, busy_v[i]}, {31'd0, mst[i] == M_RUN});
      chk($sformatf("d%0d_done", i), {31'd0, done_v[i]}, {31'd0, mst[i] == M_DONE});
      chk($sformatf("d%0d_sum", i), sum_of(i), {24'd0, held[i].s});
      chk($sformatf("d%0d_cout", i), {31'd0, cout_v[i]}, {31'd0, held[i].c});
      chk($sformatf("d%0d_ovf", i), {31'd0, ovf_v[i]}, {31'd0, held[i].v});
    end
  end

  task automatic set_in(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic s);
    case (i)
      0:       begin a0 = a; b0 = b; end
      1:       begin a1 = a; b1 = b; end
      default: begin a2 = a[3:0]; b2 = b[3:0]; end
    endcase
    cin_v[i]   = c;
    start_v[i] = s;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after DONE.
  // Operands are scrambled after acceptance to show they were captured.
  task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
    set_in(i, a, b, c, 1'b1);
    @(negedge clk);
    set_in(i, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    repeat (MN[i] + 1) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_sum0", {24'd0, sum0}, 32'd0);
    chk("reset_busy0", {31'd0, busy_v[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic add, 8 RUN cycles
    run_op(0, 8'h0F, 8'h01, 1'b0);
    chk("t1_sum", {24'd0, sum0}, 32'h10);
    chk("t1_cout", {31'd0, cout_v[0]}, 32'd0);

    // carry-out and signed overflow corners
    run_op(0, 8'hFF, 8'h01, 1'b0);
    chk("t2a_sum", {24'd0, sum0}, 32'h00);
    chk("t2a_cout", {31'd0, cout_v[0]}, 32'd1);
    chk("t2a_ovf", {31'd0, ovf_v[0]}, 32'd0);
    run_op(0, 8'h7F, 8'h00, 1'b1);
    chk("t2b_sum", {24'd0, sum0}, 32'h80);
    chk("t2b_ovf", {31'd0, ovf_v[0]}, 32'd1);

    // start held high: back-to-back ops; pulses during RUN are ignored
    start_v[0] = 1'b1;
    repeat (45) begin
      set_in(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    repeat (12) @(negedge clk);

    // reset mid-RUN abandons the op
    set_in(0, 8'hAA, 8'h55, 1'b0, 1'b1);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("t4_sum", {24'd0, sum0}, 32'd0);
    repeat (3) @(negedge clk);
    run_op(0, 8'h12, 8'h34, 1'b0);
    chk("t4_sum2", {24'd0, sum0}, 32'h46);

    // DIGIT=4 instance
    run_op(1, 8'h99, 8'h77, 1'b1);
    chk("t5_sum", {24'd0, sum1}, 32'h11);
    chk("t5_cout", {31'd0, cout_v[1]}, 32'd1);
    chk("t5_ovf", {31'd0, ovf_v[1]}, 32'd0);
    repeat (6) run_op(1, 8'($urandom), 8'($urandom), 1'($urandom));

    // exhaustive WIDTH=4, DIGIT=2, back-to-back
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          set_in(2, 8'(ai), 8'(bi), 1'(ci), 1'b1);
          repeat (3) @(negedge clk);
        end
      end
    end
    start_v[2] = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised multi-cycle adder. It adds two WIDTH-bit operands plus a carry-in, processing DIGIT bits per clock, LSB first. Start/busy/done handshake; the result is held stable until the next accepted start. It is the sequential, width-generic successor to the single-bit full adder, for area-constrained datapaths where a WIDTH-bit ripple adder is too large.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥1.
DIGIT, 1, bits added per clock; must divide WIDTH exactly (elaboration-time assertion).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled on rising edge when not busy.
a  input  WIDTH  operand A; captured at accepted start only.
b  input  WIDTH  operand B; captured at accepted start only.
c_in  input  1  carry-in; captured at accepted start only.
busy  output  1  high while an addition is in progress.
done  output  1  one-cycle pulse when the result is updated.
sum  output  WIDTH  result of the last completed addition.
c_out  output  1  unsigned carry-out of the last completed addition.
overflow  output  1  signed (two's-complement) overflow of the last completed addition.

Behaviour:
- Reset is synchronous and active-high on clk. When rst is sampled high, the next state is IDLE. busy, done, sum, c_out, overflow, the carry register and the digit counter all become 0. rst has priority over start.
- N = WIDTH/DIGIT.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → load a, b into shift registers, carry ← c_in, count ← 0 → RUN. start=0 → stay in IDLE.
  - RUN: each cycle, add the low DIGIT bits of both shift registers plus the carry register. Shift the DIGIT-bit partial sum into the accumulator from the MSB end. Update carry. Shift the operands right by DIGIT. count++. When count == N-1 in this cycle → DONE.
  - DONE: lasts exactly one cycle.
    - start=1 → accept new operands immediately → RUN (back-to-back).
    - start=0 → IDLE.
- Outputs:
  - busy = (state == RUN).
  - done = (state == DONE), one cycle wide.
- Result registers sum, c_out and overflow load on the last RUN cycle, so they are valid in the same cycle done is high. They hold unchanged through subsequent IDLE and RUN cycles until the next completion. Intermediate accumulator values never appear on sum.
- Latency: start accepted at edge k → done high during the cycle after edge k+N. With back-to-back starts, throughput is one result per N+1 cycles.
- start while busy is ignored; it is not queued. a, b and c_in may change freely after acceptance.
- overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, computed within the final digit.
- WIDTH=DIGIT (N=1): RUN lasts one cycle.
- rst mid-RUN: the operation is abandoned, no done pulse is produced, and outputs clear to 0.

Decomposition:
- serial_adder_pkg:
  - state typedef enum {IDLE, RUN, DONE};
  - function clog2-based counter width helper.
- One sub-module: digit_adder #(DIGIT). Combinational DIGIT-bit ripple adder with inputs a_d, b_d, cin and outputs s_d, cout, and c_msb (carry into the top bit, used for overflow). Instantiated once in serial_adder.

Test Plan:
1. WIDTH=8, DIGIT=1: a=0x0F, b=0x01, c_in=0, start pulse → busy for 8 cycles, done on cycle 9; sum=0x10, c_out=0, overflow=0.
2. a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1, overflow=0. Then a=0x7F, b=0x00, c_in=1 → sum=0x80, c_out=0, overflow=1.
3. Start held high continuously with changing operands → a new op is accepted in each DONE cycle; results every 9 cycles. start pulses mid-RUN do not change the result or timing.
4. rst asserted at RUN cycle 4 of a=0xAA, b=0x55 → next cycle busy=0, sum=0; no done pulse. Then a new start completes normally: 0x12+0x34 → 0x46.
5. WIDTH=8, DIGIT=4 instance: a=0x99, b=0x77, c_in=1 → done 2 cycles after start; sum=0x11, c_out=1, overflow=0.
6. Exhaustive WIDTH=4, DIGIT=2 sweep of all a, b, c_in (512 cases) against the reference model {c_out,sum} = a+b+c_in, plus signed overflow check.
